// File: rtl/conv_mesh_seq_pkg.sv
// Shared types and helpers for the conv_mesh_seq output-stationary MAC mesh.
// sat_shift is reused by other conv units, so it is written width-agnostic.
package conv_mesh_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRELOAD = 2'd1,
    ACCUM   = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  function automatic int row_idx_w(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  // Arithmetic right shift then clamp to a signed w-bit range; caller truncates to w bits.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] v,
                                                  input logic [4:0]         sh,
                                                  input int                 w);
    logic signed [63:0] shifted;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    shifted = v >>> sh;
    hi      = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    if (shifted > hi) return hi;
    if (shifted < lo) return lo;
    return shifted;
  endfunction

endpackage

// File: rtl/conv_mesh_seq_if.sv
// Handshake bundle for conv_mesh_seq: config, operand beats and drained rows.
// Every channel is valid/ready: a transfer happens on a rising edge where both are high.
interface conv_mesh_seq_if
  import conv_mesh_seq_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int W      = 8,
  parameter int ACC_W  = 20,
  parameter int KLEN_W = 8
);
  localparam int RIDX_W = row_idx_w(ROWS);

  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [KLEN_W-1:0]       cfg_klen;
  logic                    cfg_psum_en;
  logic [4:0]              cfg_shift;

  logic                    in_valid;
  logic                    in_ready;
  logic [ROWS*W-1:0]       k_in;
  logic [COLS*W-1:0]       n_in;
  logic [COLS*ACC_W-1:0]   psum_in;

  logic                    out_valid;
  logic                    out_ready;
  logic [COLS*W-1:0]       out_data;
  logic [RIDX_W-1:0]       out_row;

  logic                    busy;
  state_t                  dbg_state;

  modport slave (
    input  cfg_valid, cfg_klen, cfg_psum_en, cfg_shift,
    input  in_valid, k_in, n_in, psum_in,
    input  out_ready,
    output cfg_ready, in_ready, out_valid, out_data, out_row, busy, dbg_state
  );

  modport master (
    output cfg_valid, cfg_klen, cfg_psum_en, cfg_shift,
    output in_valid, k_in, n_in, psum_in,
    output out_ready,
    input  cfg_ready, in_ready, out_valid, out_data, out_row, busy, dbg_state
  );

endinterface

// File: rtl/conv_mesh_seq_pe.sv
// Single signed MAC cell of the mesh; clear has priority over load, load over accumulate.
module conv_pe #(
  parameter int W     = 8,
  parameter int ACC_W = 20
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    clear,
  input  logic                    load,
  input  logic                    en,
  input  logic signed [W-1:0]     k,
  input  logic signed [W-1:0]     n,
  input  logic signed [ACC_W-1:0] psum,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*W-1:0] prod;

  assign prod = k * n;

  // Accumulation wraps modulo 2^ACC_W by construction.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      acc <= '0;
    end else if (load) begin
      acc <= psum;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/conv_mesh_seq.sv
// ROWS x COLS output-stationary MAC mesh that sequences one job:
// config, optional psum preload, klen accumulate beats, then a row-by-row saturating drain.
module conv_mesh_seq
  import conv_mesh_seq_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int W      = 8,
  parameter int ACC_W  = 20,
  parameter int KLEN_W = 8
) (
  input  logic           CLK,
  input  logic           RST,
  conv_mesh_seq_if.slave bus
);

  localparam int RIDX_W = row_idx_w(ROWS);

  state_t            state_q, state_d;
  logic [KLEN_W-1:0] klen_q;
  logic [4:0]        shift_q;
  logic [KLEN_W-1:0] beat_q;
  logic [RIDX_W-1:0] pre_row_q;
  logic [RIDX_W-1:0] out_row_q;

  logic cfg_fire, in_fire, out_fire;
  logic pre_fire, acc_fire;
  logic pre_last, acc_last, out_last;

  logic signed [ACC_W-1:0] pe_acc [ROWS][COLS];
  logic [COLS*W-1:0]       data_d;

  assign bus.cfg_ready = (state_q == IDLE);
  assign bus.in_ready  = (state_q == PRELOAD) || (state_q == ACCUM);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_row   = out_row_q;
  assign bus.out_data  = data_d;
  assign bus.dbg_state = state_q;

  assign cfg_fire = bus.cfg_valid && bus.cfg_ready;
  assign in_fire  = bus.in_valid  && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign pre_fire = in_fire && (state_q == PRELOAD);
  assign acc_fire = in_fire && (state_q == ACCUM);

  assign pre_last = (pre_row_q == RIDX_W'(ROWS - 1));
  assign acc_last = (beat_q == klen_q - KLEN_W'(1));
  assign out_last = (out_row_q == RIDX_W'(ROWS - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_fire) begin
          if (bus.cfg_psum_en)               state_d = PRELOAD;
          else if (bus.cfg_klen != '0)       state_d = ACCUM;
          else                               state_d = DRAIN;
        end
      end
      PRELOAD: begin
        if (pre_fire && pre_last) state_d = (klen_q != '0) ? ACCUM : DRAIN;
      end
      ACCUM: begin
        if (acc_fire && acc_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_fire && out_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      klen_q    <= '0;
      shift_q   <= '0;
      beat_q    <= '0;
      pre_row_q <= '0;
      out_row_q <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_fire) begin
        klen_q    <= bus.cfg_klen;
        shift_q   <= bus.cfg_shift;
        beat_q    <= '0;
        pre_row_q <= '0;
        out_row_q <= '0;
      end
      if (pre_fire) pre_row_q <= pre_row_q + RIDX_W'(1);
      if (acc_fire) beat_q    <= beat_q + KLEN_W'(1);
      if (out_fire) out_row_q <= out_last ? '0 : out_row_q + RIDX_W'(1);
    end
  end

  // Kernel lane r feeds mesh row r, neuron lane c feeds mesh column c.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      conv_pe #(
        .W     (W),
        .ACC_W (ACC_W)
      ) u_pe (
        .CLK   (CLK),
        .RST   (RST),
        .clear (cfg_fire),
        .load  (pre_fire && (pre_row_q == RIDX_W'(r))),
        .en    (acc_fire),
        .k     (bus.k_in[W*(r+1)-1 -: W]),
        .n     (bus.n_in[W*(c+1)-1 -: W]),
        .psum  (bus.psum_in[ACC_W*(c+1)-1 -: ACC_W]),
        .acc   (pe_acc[r][c])
      );
    end
  end

  // Drain row is a pure function of out_row_q, so it holds while the consumer stalls.
  always_comb begin
    data_d = '0;
    if (state_q == DRAIN) begin
      for (int c = 0; c < COLS; c++) begin
        data_d[c*W +: W] = W'(sat_shift(64'(pe_acc[out_row_q][c]), shift_q, W));
      end
    end
  end

endmodule

// File: tb/tb_conv_mesh_seq.sv
// Self-checking bench for conv_mesh_seq: table-driven jobs, model-driven random jobs,
// and hand sequences for gaps, backpressure and mid-job reset; drained rows go through exp_q.
module tb_conv_mesh_seq;
  import conv_mesh_seq_pkg::*;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int W      = 8;
  localparam int ACC_W  = 20;
  localparam int KLEN_W = 8;
  localparam int RIDX_W = 2;
  localparam int EW     = RIDX_W + COLS*W;
  localparam int MAXB   = 8;

  typedef struct {
    int klen;
    bit psum_en;
    int psum;
    int shift;
    int k;
    int n;
    int exp_lane;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  conv_mesh_seq_if #(.ROWS(ROWS), .COLS(COLS), .W(W), .ACC_W(ACC_W), .KLEN_W(KLEN_W)) bus ();

  conv_mesh_seq #(.ROWS(ROWS), .COLS(COLS), .W(W), .ACC_W(ACC_W), .KLEN_W(KLEN_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [EW-1:0] exp_q[$];

  int job_psum [ROWS][COLS];
  int job_k    [MAXB][ROWS];
  int job_n    [MAXB][COLS];

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    $display("FAIL %s: got no handshake within bound, expected one", name);
  endtask

  function automatic int sat_w(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Scoreboard side: every accepted drain row is popped and compared.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_row: got row %0d data %0h, expected no row", bus.out_row, bus.out_data);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("drain_row", 64'({bus.out_row, bus.out_data}), 64'(e));
      end
    end
  end

  task automatic push_const(input int val);
    logic [COLS*W-1:0] row;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) row[c*W +: W] = W'(val);
      exp_q.push_back({RIDX_W'(r), row});
    end
  endtask

  task automatic push_model(input int klen, input bit pe, input int sh);
    logic [COLS*W-1:0] row;
    int a;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        a = pe ? job_psum[r][c] : 0;
        for (int b = 0; b < klen; b++) a += job_k[b][r] * job_n[b][c];
        row[c*W +: W] = W'(sat_w(a >>> sh));
      end
      exp_q.push_back({RIDX_W'(r), row});
    end
  endtask

  task automatic fill_uniform(input int k, input int n, input int psum);
    for (int b = 0; b < MAXB; b++) begin
      for (int r = 0; r < ROWS; r++) job_k[b][r] = k;
      for (int c = 0; c < COLS; c++) job_n[b][c] = n;
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) job_psum[r][c] = psum;
  endtask

  // All drivers enter and leave at posedge+#1 so a beat is offered for exactly one edge.
  task automatic drive_cfg(input int klen, input bit pe, input int sh);
    bit ok;
    int waited;
    bus.cfg_klen    = KLEN_W'(klen);
    bus.cfg_psum_en = pe;
    bus.cfg_shift   = 5'(sh);
    bus.cfg_valid   = 1'b1;
    ok = 0;
    waited = 0;
    while (!ok && waited < 20) begin
      @(negedge clk);
      if (bus.cfg_ready) ok = 1;
      else begin
        @(posedge clk); #1;
      end
      waited++;
    end
    if (!ok) fail_timeout("cfg_handshake");
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    check("cfg_ready_after_cfg", bus.cfg_ready, 0);
    if (pe || klen != 0) check("cfg_to_in_ready", bus.in_ready, 1);
    else                 check("cfg_to_out_valid", bus.out_valid, 1);
  endtask

  task automatic drive_beat(input logic [ROWS*W-1:0] k, input logic [COLS*W-1:0] n,
                            input logic [COLS*ACC_W-1:0] psum);
    bit ok;
    int waited;
    bus.k_in     = k;
    bus.n_in     = n;
    bus.psum_in  = psum;
    bus.in_valid = 1'b1;
    ok = 0;
    waited = 0;
    while (!ok && waited < 20) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      else begin
        @(posedge clk); #1;
      end
      waited++;
    end
    if (!ok) fail_timeout("in_handshake");
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_job(input int klen, input bit pe, input int sh, input int gap);
    logic [ROWS*W-1:0]     kv;
    logic [COLS*W-1:0]     nv;
    logic [COLS*ACC_W-1:0] pv;
    drive_cfg(klen, pe, sh);
    if (pe) begin
      for (int p = 0; p < ROWS; p++) begin
        for (int c = 0; c < COLS; c++) pv[c*ACC_W +: ACC_W] = ACC_W'(job_psum[p][c]);
        drive_beat('0, '0, pv);
      end
    end
    for (int b = 0; b < klen; b++) begin
      for (int r = 0; r < ROWS; r++) kv[r*W +: W] = W'(job_k[b][r]);
      for (int c = 0; c < COLS; c++) nv[c*W +: W] = W'(job_n[b][c]);
      drive_beat(kv, nv, '0);
      if (b < klen - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          check("gap_cfg_ready", bus.cfg_ready, 0);
        end
      end
    end
    if (pe || klen != 0) check("last_beat_to_out_valid", bus.out_valid, 1);
  endtask

  task automatic wait_drain();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (exp_q.size() != 0) begin
      fail_timeout("drain_complete");
      exp_q.delete();
    end
    check("drain_done_busy", bus.busy, 0);
    check("drain_done_out_valid", bus.out_valid, 0);
    check("drain_done_cfg_ready", bus.cfg_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cfg_valid   = 1'b0;
    bus.cfg_klen    = '0;
    bus.cfg_psum_en = 1'b0;
    bus.cfg_shift   = '0;
    bus.in_valid    = 1'b0;
    bus.k_in        = '0;
    bus.n_in        = '0;
    bus.psum_in     = '0;
    bus.out_ready   = 1'b1;

    vecs[0] = '{klen: 1, psum_en: 0, psum: 0,   shift: 0, k: 2,    n: 3,   exp_lane: 6};
    vecs[1] = '{klen: 4, psum_en: 0, psum: 0,   shift: 0, k: 127,  n: 127, exp_lane: 127};
    vecs[2] = '{klen: 4, psum_en: 0, psum: 0,   shift: 9, k: 127,  n: 127, exp_lane: 126};
    vecs[3] = '{klen: 2, psum_en: 0, psum: 0,   shift: 0, k: -128, n: 127, exp_lane: -128};
    vecs[4] = '{klen: 2, psum_en: 0, psum: 0,   shift: 8, k: -128, n: 127, exp_lane: -127};
    vecs[5] = '{klen: 1, psum_en: 1, psum: 100, shift: 0, k: 1,    n: 1,   exp_lane: 101};
    vecs[6] = '{klen: 0, psum_en: 1, psum: 100, shift: 0, k: 5,    n: 5,   exp_lane: 100};
    vecs[7] = '{klen: 0, psum_en: 0, psum: 0,   shift: 0, k: 9,    n: 9,   exp_lane: 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_ready", bus.cfg_ready, 1);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out_row", 64'(bus.out_row), 0);
    check("rst_out_data", 64'(bus.out_data), 0);
    check("rst_state", 64'(bus.dbg_state), 64'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      fill_uniform(vecs[i].k, vecs[i].n, vecs[i].psum);
      push_const(vecs[i].exp_lane);
      run_job(vecs[i].klen, vecs[i].psum_en, vecs[i].shift, 0);
      wait_drain();
    end

    // klen=3 with two idle cycles between beats: 2*1 + 2*2 + 2*3 = 12
    fill_uniform(2, 0, 0);
    for (int b = 0; b < 3; b++)
      for (int c = 0; c < COLS; c++) job_n[b][c] = b + 1;
    push_const(12);
    run_job(3, 0, 0, 2);
    wait_drain();

    // Backpressure at row 1 with garbage offered on the input channel meanwhile
    fill_uniform(2, 3, 0);
    bus.out_ready = 1'b0;
    push_const(6);
    run_job(1, 0, 0, 0);
    check("bp_first_row", 64'(bus.out_row), 0);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.k_in      = {ROWS{8'h7f}};
    bus.n_in      = {COLS{8'h7f}};
    check("drain_in_ready", bus.in_ready, 0);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("bp_out_row", 64'(bus.out_row), 1);
      check("bp_out_data", 64'(bus.out_data), 64'({COLS{8'd6}}));
      check("bp_out_valid", bus.out_valid, 1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_drain();
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset pulsed in the middle of ACCUM
    fill_uniform(5, 7, 0);
    drive_cfg(4, 0, 0);
    drive_beat({ROWS{8'd5}}, {COLS{8'd7}}, '0);
    drive_beat({ROWS{8'd5}}, {COLS{8'd7}}, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_cfg_ready", bus.cfg_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    fill_uniform(2, 3, 0);
    push_const(6);
    run_job(1, 0, 0, 0);
    wait_drain();

    // Random jobs with distinct per-lane operands
    for (int j = 0; j < 4; j++) begin
      int klen;
      bit pe;
      int sh;
      klen = int'($urandom_range(1, 5));
      pe   = 1'($urandom_range(0, 1));
      sh   = int'($urandom_range(0, 10));
      for (int b = 0; b < MAXB; b++) begin
        for (int r = 0; r < ROWS; r++) job_k[b][r] = int'($urandom_range(0, 255)) - 128;
        for (int c = 0; c < COLS; c++) job_n[b][c] = int'($urandom_range(0, 255)) - 128;
      end
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) job_psum[r][c] = int'($urandom_range(0, 2000)) - 1000;
      push_model(klen, pe, sh);
      run_job(klen, pe, sh, int'($urandom_range(0, 1)));
      wait_drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
